// File: rtl/mlp_inference_sequencer.sv
// Bus master that runs one complete digit inference on the Multilayer_Perceptron slave:
// configure, stream pixels, start the core, poll, read scores, argmax. Optional macro: MLP_WATCHDOG_EN.
module mlp_inference_sequencer #(
  parameter int N_IN    = 64,
  parameter int M_HID   = 32,
  parameter int H_OUT   = 10,
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_write,
  output logic        bus_read,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  digit,
  output logic [7:0]  score,
  output logic        error
);

  localparam logic [15:0] ADDR_CTRL = 16'h0004;
  localparam logic [15:0] ADDR_STAT = 16'h0008;
  localparam logic [15:0] ADDR_N    = 16'h0010;
  localparam logic [15:0] ADDR_M    = 16'h0014;
  localparam logic [15:0] ADDR_H    = 16'h0018;
  localparam logic [15:0] ADDR_IMEM = 16'h1000;
  localparam logic [15:0] ADDR_OMEM = 16'h1800;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_LOAD, S_RUN, S_WAIT, S_READ, S_CLR, S_DONE, S_TSCLR, S_TCLR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [15:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic signed [7:0] best_q, best_d, rd_score;
  logic [3:0]        best_idx_q, best_idx_d, digit_q, digit_d;
  logic [7:0]        score_q, score_d;
  logic              unused_ok;

`ifdef MLP_WATCHDOG_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 32'h0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      best_q     <= 8'sd0;
      best_idx_q <= 4'd0;
      digit_q    <= 4'd0;
      score_q    <= 8'd0;
`ifdef MLP_WATCHDOG_EN
      tmo_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      score_q    <= score_d;
`ifdef MLP_WATCHDOG_EN
      tmo_q      <= tmo_d;
      error_q    <= error_d;
`endif
    end
  end

  // The _d bus fields describe the transaction the bus will carry during the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 8'd1;
    addr_d     = 16'h0000;
    wdata_d    = 32'h0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    score_d    = score_q;
    rd_score   = signed'(bus_rdata[7:0]);
`ifdef MLP_WATCHDOG_EN
    tmo_d      = tmo_q;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CFG;
          cnt_d   = 8'd1;
          wr_d    = 1'b1;
          addr_d  = ADDR_N;
          wdata_d = 32'(N_IN);
`ifdef MLP_WATCHDOG_EN
          error_d = 1'b0;
`endif
        end
      end
      S_CFG: begin
        wr_d  = 1'b1;
        cnt_d = cnt_inc;
        case (cnt_q[1:0])
          2'd1: begin
            addr_d  = ADDR_M;
            wdata_d = 32'(M_HID);
          end
          2'd2: begin
            addr_d  = ADDR_H;
            wdata_d = 32'(H_OUT);
          end
          default: begin
            addr_d  = ADDR_CTRL;
            wdata_d = 32'h1;
            state_d = S_LOAD;
            cnt_d   = 8'd0;
          end
        endcase
      end
      S_LOAD: begin
        if (pix_valid) begin
          wr_d    = 1'b1;
          addr_d  = ADDR_IMEM + {8'h00, cnt_q};
          wdata_d = {24'h0, pix_data};
          cnt_d   = cnt_inc;
          if (cnt_q == 8'(N_IN - 1)) begin
            state_d = S_RUN;
            cnt_d   = 8'd0;
          end
        end
      end
      S_RUN: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = 32'h2;
        state_d = S_WAIT;
`ifdef MLP_WATCHDOG_EN
        tmo_d   = '0;
`endif
      end
      // rd_q gates the done test so the control write cycle on entry is never mistaken for a poll.
      S_WAIT: begin
        rd_d   = 1'b1;
        addr_d = ADDR_STAT;
        if (rd_q && bus_rdata[0]) begin
          addr_d  = ADDR_OMEM;
          state_d = S_READ;
          cnt_d   = 8'd0;
        end
`ifdef MLP_WATCHDOG_EN
        else if (tmo_q == TW'(TMO_CYC - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = 32'h4;
          state_d = S_TSCLR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_READ: begin
        if (cnt_q == 8'd0 || rd_score > best_q) begin
          best_d     = rd_score;
          best_idx_d = cnt_q[3:0];
        end
        if (cnt_q == 8'(H_OUT - 1)) begin
          wr_d    = 1'b1;
          addr_d  = ADDR_CTRL;
          state_d = S_CLR;
        end else begin
          rd_d   = 1'b1;
          addr_d = ADDR_OMEM + {8'h00, cnt_inc};
          cnt_d  = cnt_inc;
        end
      end
      S_CLR: begin
        digit_d = best_idx_q;
        score_d = best_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
`ifdef MLP_WATCHDOG_EN
      S_TSCLR: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        state_d = S_TCLR;
      end
      S_TCLR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign pix_ready    = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_write    = wr_q;
  assign bus_read     = rd_q;
  assign digit        = digit_q;
  assign score        = score_q;
`ifdef MLP_WATCHDOG_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

  assign unused_ok = ^{bus_rdata[31:8], (TMO_CYC > 0)};

endmodule

// File: tb/tb_mlp_inference_sequencer.sv
// Self-checking bench for mlp_inference_sequencer: a behavioural MLP slave answers the bus,
// and expected traffic/argmax are derived from the random pixels and scores of each run.
module tb_mlp_inference_sequencer;
  localparam int N_IN    = 64;
  localparam int M_HID   = 32;
  localparam int H_OUT   = 10;
  localparam int TMO_CYC = 16;
`ifdef MLP_WATCHDOG_EN
  localparam int CORE_DLY = 8;
`else
  localparam int CORE_DLY = 50;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        result_valid;
  logic [3:0]  digit;
  logic [7:0]  score;
  logic        error;

  logic signed [7:0] outs [16];
  logic [7:0]        pix [N_IN];
  logic              done = 1'b0;
  bit                coreRun = 1'b0;
  int                coreCnt = 0;
  int                coreDelay = CORE_DLY;
  int                cycleCount = 0;
  int                conflicts = 0;
  int                resultCount = 0;
  logic [3:0]        resDigit = 4'd0;
  logic [7:0]        resScore = 8'd0;
  logic [15:0]       wrAddr [$];
  logic [31:0]       wrData [$];
  int                wrCyc [$];
  logic [15:0]       rdAddr [$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  mlp_inference_sequencer #(
    .N_IN(N_IN), .M_HID(M_HID), .H_OUT(H_OUT), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
    .bus_rdata(bus_rdata), .busy(busy), .result_valid(result_valid),
    .digit(digit), .score(score), .error(error)
  );

  // Slave read port: status and output memory, upper data bits filled with junk.
  always_comb begin
    bus_rdata = 32'h0;
    if (bus_addr == 16'h0008) bus_rdata = {31'h0, done};
    else if (bus_addr[15:4] == 12'h180) bus_rdata = {24'hA5C3E1, outs[bus_addr[3:0]]};
  end

  // Bus logger plus a slave core that raises done coreDelay cycles after run is written.
  always @(negedge clk) begin
    cycleCount++;
    if (reset) begin
      done = 1'b0;
      coreRun = 1'b0;
    end else begin
      if (bus_write && bus_read) conflicts++;
      if (bus_write) begin
        wrAddr.push_back(bus_addr);
        wrData.push_back(bus_wdata);
        wrCyc.push_back(cycleCount);
        if (bus_addr == 16'h0004) begin
          if (bus_wdata == 32'h2) begin
            coreRun = 1'b1;
            coreCnt = coreDelay;
          end else begin
            done = 1'b0;
          end
        end
      end else if (bus_read) begin
        rdAddr.push_back(bus_addr);
      end
      if (result_valid) begin
        resultCount++;
        resDigit = digit;
        resScore = score;
      end
      if (coreRun) begin
        if (coreCnt == 0) begin
          done = 1'b1;
          coreRun = 1'b0;
        end else begin
          coreCnt--;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feedPixels(input bit stall, input int count);
    int i;
    int cyc;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < count && cyc < 2000) begin
      pix_valid = !(stall && (cyc % 3 == 2));
      pix_data  = pix[i];
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    pix_valid = 1'b0;
    checkOutput("pix_accepted", i, count);
  endtask

  // One full inference; all expectations come from pix[] and outs[].
  task automatic applyStimulus(input string name, input bit stall, input int delay, input bit pokeStart);
    int wBase, rBase, resBase, guard, nW, nR, bad, win;
    bit poked;
    logic signed [7:0] mx;
    logic [15:0] eA [$];
    logic [31:0] eD [$];
    coreDelay = delay;
    wBase = wrAddr.size();
    rBase = rdAddr.size();
    resBase = resultCount;
    pulseStart();
    feedPixels(stall, N_IN);
    guard = 0;
    poked = 1'b0;
    while (resultCount == resBase && guard < 3000) begin
      if (pokeStart && !poked && bus_read && bus_addr[15:4] == 12'h180) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    checkOutput({name, " result_seen"}, resultCount > resBase, 1);
    if (pokeStart) checkOutput({name, " start_poked"}, poked, 1);
    repeat (20) @(posedge clk);
    #1;

    eA = {16'h0010, 16'h0014, 16'h0018, 16'h0004};
    eD = {32'(N_IN), 32'(M_HID), 32'(H_OUT), 32'h1};
    for (int i = 0; i < N_IN; i++) begin
      eA.push_back(16'h1000 + 16'(i));
      eD.push_back({24'h0, pix[i]});
    end
    eA.push_back(16'h0004); eD.push_back(32'h2);
    eA.push_back(16'h0004); eD.push_back(32'h0);

    nW = wrAddr.size() - wBase;
    checkOutput({name, " wr_count"}, nW, eA.size());
    for (int k = 0; k < eA.size() && k < nW; k++) begin
      checkOutput($sformatf("%s wr_addr[%0d]", name, k), wrAddr[wBase + k], eA[k]);
      checkOutput($sformatf("%s wr_data[%0d]", name, k), wrData[wBase + k], eD[k]);
    end
    for (int k = 1; k < 4 && k < nW; k++)
      checkOutput($sformatf("%s cfg_consecutive[%0d]", name, k), wrCyc[wBase + k] - wrCyc[wBase], k);

    nR = rdAddr.size() - rBase;
    checkOutput({name, " rd_count_gt_h"}, nR > H_OUT, 1);
    if (nR > H_OUT) begin
      bad = 0;
      for (int k = 0; k < nR - H_OUT; k++)
        if (rdAddr[rBase + k] != 16'h0008) bad++;
      checkOutput({name, " status_poll_addr"}, bad, 0);
      for (int k = 0; k < H_OUT; k++)
        checkOutput($sformatf("%s rd_addr[%0d]", name, k), rdAddr[rBase + nR - H_OUT + k], 16'h1800 + 16'(k));
    end

    mx = outs[0];
    for (int k = 1; k < H_OUT; k++)
      if (outs[k] > mx) mx = outs[k];
    win = -1;
    for (int k = 0; k < H_OUT; k++)
      if (win < 0 && outs[k] == mx) win = k;
    checkOutput({name, " result_pulses"}, resultCount - resBase, 1);
    checkOutput({name, " digit"}, {28'h0, resDigit}, win);
    checkOutput({name, " score"}, {24'h0, resScore}, {24'h0, mx});
    checkOutput({name, " digit_held"}, {28'h0, digit}, win);
    checkOutput({name, " busy_after"}, busy, 0);
    checkOutput({name, " error"}, error, 0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " pix_ready"}, pix_ready, 0);
    checkOutput({name, " busy"}, busy, 0);
    checkOutput({name, " bus_write"}, bus_write, 0);
    checkOutput({name, " bus_read"}, bus_read, 0);
    checkOutput({name, " bus_addr"}, bus_addr, 0);
    checkOutput({name, " result_valid"}, result_valid, 0);
    checkOutput({name, " digit"}, digit, 0);
    checkOutput({name, " score"}, score, 0);
    checkOutput({name, " error"}, error, 0);
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) pix[i] = 8'($urandom);
    for (int k = 0; k < 16; k++) outs[k] = 8'sd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("por");
    reset = 1'b0;

    // Fixed argmax with a tie at 2/3, pixels stalled every third cycle.
    for (int k = 0; k < H_OUT; k++) outs[k] = 8'(int'($urandom_range(0, 147)) - 128);
    outs[0] = 8'sd5; outs[1] = -8'sd3; outs[2] = 8'sd20; outs[3] = 8'sd20; outs[4] = 8'sd7;
    applyStimulus("argmax", 1'b1, CORE_DLY, 1'b0);

    // Reset held three cycles in the middle of pixel loading.
    pulseStart();
    pix_valid = 1'b1;
    repeat (10) begin
      pix_data = 8'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("midload pix_ready", pix_ready, 1);
    reset = 1'b1;
    pix_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkResetState("midload_reset");
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after_reset busy", busy, 0);

    // All minimum scores except the last class; start poked during the read phase.
    for (int i = 0; i < N_IN; i++) pix[i] = 8'($urandom);
    for (int k = 0; k < H_OUT; k++) outs[k] = -8'sd128;
    outs[9] = -8'sd1;
    applyStimulus("negatives", 1'b0, CORE_DLY, 1'b1);

    // Random runs; the narrow score range makes ties frequent.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_IN; i++) pix[i] = 8'($urandom);
      for (int k = 0; k < H_OUT; k++)
        outs[k] = (r == 2) ? 8'($urandom) : 8'(int'($urandom_range(0, 7)) - 4);
      applyStimulus($sformatf("random%0d", r), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, CORE_DLY)), 1'b0);
    end

    checkOutput("strobe_conflicts", conflicts, 0);

`ifdef MLP_WATCHDOG_EN
    begin
      int resBase, guard, n;
      coreDelay = 1000000;
      resBase = resultCount;
      pulseStart();
      feedPixels(1'b0, N_IN);
      guard = 0;
      while (error !== 1'b1 && guard < 300) begin
        @(posedge clk); #1;
        guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("wd error", error, 1);
      checkOutput("wd no_result", resultCount - resBase, 0);
      checkOutput("wd busy", busy, 0);
      n = wrAddr.size();
      checkOutput("wd wr_run", wrData[n - 3], 32'h2);
      checkOutput("wd wr_softclr_addr", wrAddr[n - 2], 16'h0004);
      checkOutput("wd wr_softclr", wrData[n - 2], 32'h4);
      checkOutput("wd wr_clr_addr", wrAddr[n - 1], 16'h0004);
      checkOutput("wd wr_clr", wrData[n - 1], 32'h0);
      pulseStart();
      checkOutput("wd error_cleared", error, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
